// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority arbitrating mux.
package arb_mux_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  // Ceiling log2, never below 1 so a channel index always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between NUM_CH producers, the arbitrating mux and one consumer.
interface rr_arb_mux_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 32
);
  import arb_mux_pkg::*;

  localparam int unsigned CH_W = clog2(NUM_CH);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_ready;

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  // Mux side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_grant_picker.sv
// Combinational grant selection: rotate requests to start after ptr, then take the lowest set bit.
module rr_grant_picker
  import arb_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any_grant
);

  localparam int unsigned SW = CH_W + 1;

  logic [CH_W-1:0]     start;
  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   rot;
  logic [CH_W-1:0]     off;
  logic [SW-1:0]       sum;

  always_comb begin
    start = '0;
    if (!mode) begin
      start = (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + CH_W'(1);
    end
    req_dbl = {req, req};
    rot     = NUM_CH'(req_dbl >> start);
    off     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = CH_W'(i);
    end
    // Undo the rotation; wrap at NUM_CH so non-power-of-two counts never overflow the range.
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= SW'(NUM_CH)) grant_idx = CH_W'(sum - SW'(NUM_CH));
    else                    grant_idx = sum[CH_W-1:0];
    any_grant = |req;
    grant     = any_grant ? (NUM_CH'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// NUM_CH:1 arbitrating mux with a registered output slot; round-robin or fixed priority by MODE.
module rr_arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MODE   = MODE_RR
) (
  input logic          clk,
  input logic          rst_n,
  rr_arb_mux_if.slave  bus
);

  localparam int unsigned CH_W = clog2(NUM_CH);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [CH_W-1:0]   out_ch_q,    out_ch_d;
  logic [CH_W-1:0]   rr_ptr_q,    rr_ptr_d;

  logic              load_c;
  logic              xfer_c;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              any_grant;
  logic [WIDTH-1:0]  sel_data;

  rr_grant_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .mode      (1'(MODE == MODE_FIXED)),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Slot is free when empty or being drained this cycle.
  assign load_c = !out_valid_q || bus.out_ready;
  assign xfer_c = load_c && any_grant;

  assign bus.in_ready  = (rst_n && xfer_c) ? grant : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_W'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state for the output slot and fairness pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
      rr_ptr_d    = grant_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= CH_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Drives a round-robin and a fixed-priority instance with identical stimulus and checks both against a queue-free reference model.
module tb_rr_arb_mux;
  import arb_mux_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.NUM_CH(N), .WIDTH(W)) bus_rr ();
  rr_arb_mux_if #(.NUM_CH(N), .WIDTH(W)) bus_fx ();

  rr_arb_mux #(.NUM_CH(N), .WIDTH(W), .MODE(MODE_RR))    dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));
  rr_arb_mux #(.NUM_CH(N), .WIDTH(W), .MODE(MODE_FIXED)) dut_fx (.clk(clk), .rst_n(rst_n), .bus(bus_fx.slave));

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] vld;
  logic [W-1:0] dat [N];
  logic         ordy;

  // Reference state per instance: 0 = round-robin, 1 = fixed priority.
  bit           m_v   [2];
  logic [W-1:0] m_d   [2];
  int           m_ch  [2];
  int           m_ptr [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    logic [N*W-1:0] pk;
    for (int i = 0; i < N; i++) pk[i*W +: W] = dat[i];
    bus_rr.in_valid = vld; bus_rr.in_data = pk; bus_rr.out_ready = ordy;
    bus_fx.in_valid = vld; bus_fx.in_data = pk; bus_fx.out_ready = ordy;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 1'b0; m_d[k] = '0; m_ch[k] = 0; m_ptr[k] = N - 1;
    end
  endtask

  function automatic int model_grant(input int k);
    if (k == 1) begin
      for (int i = 0; i < N; i++) if (vld[i]) return i;
    end else begin
      for (int s = 1; s <= N; s++) if (vld[(m_ptr[k] + s) % N]) return (m_ptr[k] + s) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] rdy_of(input int k);
    return (k == 0) ? bus_rr.in_ready : bus_fx.in_ready;
  endfunction
  function automatic logic vld_of(input int k);
    return (k == 0) ? bus_rr.out_valid : bus_fx.out_valid;
  endfunction
  function automatic logic [W-1:0] dat_of(input int k);
    return (k == 0) ? bus_rr.out_data : bus_fx.out_data;
  endfunction
  function automatic int ch_of(input int k);
    return (k == 0) ? int'(bus_rr.out_ch) : int'(bus_fx.out_ch);
  endfunction

  // One clock: inputs already applied after a falling edge; check ready, advance model, check outputs.
  task automatic step();
    int           g  [2];
    bit           ld [2];
    logic [N-1:0] er;
    string        nm;
    apply();
    #1;
    for (int k = 0; k < 2; k++) begin
      nm    = (k == 0) ? "rr" : "fx";
      g[k]  = model_grant(k);
      ld[k] = !m_v[k] || ordy;
      er    = '0;
      if (ld[k] && g[k] >= 0) er[g[k]] = 1'b1;
      chk({nm, "_in_ready"}, 64'(rdy_of(k)), 64'(er));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ld[k] && g[k] >= 0) begin
        m_v[k] = 1'b1; m_d[k] = dat[g[k]]; m_ch[k] = g[k]; m_ptr[k] = g[k];
      end else if (ordy) begin
        m_v[k] = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      nm = (k == 0) ? "rr" : "fx";
      chk({nm, "_out_valid"}, 64'(vld_of(k)), 64'(m_v[k]));
      chk({nm, "_out_data"},  64'(dat_of(k)), 64'(m_d[k]));
      chk({nm, "_out_ch"},    64'(ch_of(k)),  64'(m_ch[k]));
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_seq [3];

    // Reset held with all channels requesting.
    rst_n = 1'b0;
    ordy  = 1'b0;
    vld   = 4'b1111;
    for (int i = 0; i < N; i++) dat[i] = 32'hA0 + 32'(i);
    model_reset();
    apply();
    #2;
    chk("rst_rr_in_ready", 64'(bus_rr.in_ready), 64'd0);
    chk("rst_fx_in_ready", 64'(bus_fx.in_ready), 64'd0);
    chk("rst_out_valid",   64'(bus_rr.out_valid), 64'd0);
    chk("rst_out_data",    64'(bus_rr.out_data),  64'd0);
    chk("rst_out_ch",      64'(bus_rr.out_ch),    64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin sweep with all channels valid.
    ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sweep_rr_ch",   64'(bus_rr.out_ch),   64'(i % 4));
      chk("sweep_rr_data", 64'(bus_rr.out_data), 64'(32'hA0 + 32'(i % 4)));
      chk("sweep_rr_vld",  64'(bus_rr.out_valid), 64'd1);
      chk("sweep_fx_ch",   64'(bus_fx.out_ch),   64'd0);
    end

    // Skip and wrap: pointer parked on 2, then only 0 and 1 request.
    vld = 4'b0100;
    step();
    chk("skip_rr_ch2", 64'(bus_rr.out_ch), 64'd2);
    vld = 4'b0011;
    exp_seq = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      step();
      chk("skip_rr_ch", 64'(bus_rr.out_ch), 64'(exp_seq[i]));
    end

    // Fixed priority starves channel 3 while channel 1 requests.
    vld = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fixed_fx_ch", 64'(bus_fx.out_ch), 64'd1);
      chk("fixed_rr_ch", 64'(bus_rr.out_ch), (i % 2 == 0) ? 64'd1 : 64'd3);
    end
    vld = 4'b1000;
    step();
    chk("fixed_fx_ch3", 64'(bus_fx.out_ch), 64'd3);

    // Backpressure: hold a word from channel 2 for five cycles.
    vld    = 4'b0100;
    dat[2] = 32'hDEADBEEF;
    dat[3] = 32'h3333_0003;
    step();
    chk("bp_load_ch", 64'(bus_rr.out_ch), 64'd2);
    ordy = 1'b0;
    vld  = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_ch",    64'(bus_rr.out_ch),    64'd2);
      chk("bp_hold_data",  64'(bus_rr.out_data),  64'hDEADBEEF);
      chk("bp_hold_vld",   64'(bus_rr.out_valid), 64'd1);
      chk("bp_hold_ready", 64'(bus_rr.in_ready),  64'd0);
    end
    ordy = 1'b1;
    step();
    chk("bp_release_ch",   64'(bus_rr.out_ch),   64'd3);
    chk("bp_release_data", 64'(bus_rr.out_data), 64'h3333_0003);
    vld = 4'b0000;
    step();
    chk("drain_vld",     64'(bus_rr.out_valid), 64'd0);
    chk("drain_hold_ch", 64'(bus_rr.out_ch),    64'd3);

    // Randomized traffic with random consumer backpressure.
    for (int c = 0; c < 400; c++) begin
      vld  = N'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) dat[i] = $urandom;
      step();
    end

    // Asynchronous reset between edges while a word is pending.
    vld  = 4'b0001;
    ordy = 1'b0;
    step();
    chk("mid_pre_vld", 64'(bus_rr.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld_rr",   64'(bus_rr.out_valid), 64'd0);
    chk("mid_rst_vld_fx",   64'(bus_fx.out_valid), 64'd0);
    chk("mid_rst_ready_rr", 64'(bus_rr.in_ready),  64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vld   = 4'b0000;
    ordy  = 1'b1;
    step();
    chk("post_rst_no_stale", 64'(bus_rr.out_valid), 64'd0);
    vld = 4'b1111;
    for (int i = 0; i < N; i++) dat[i] = 32'hA0 + 32'(i);
    step();
    chk("post_rst_first_ch", 64'(bus_rr.out_ch), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
